// File: rtl/multdiv_pkg.sv
// multdiv_pkg
// Shared definitions for the multiply/divide sequencer: the FSM state
// encoding and the default iteration counts for each operation.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Radix-4 Booth multiply retires two bits per step; restoring divide one.
    localparam int MULT_STEPS_DEF = 16;
    localparam int DIV_STEPS_DEF  = 32;

endpackage

// File: rtl/multdiv_sequencer_step_counter.sv
// step_counter
// Iteration index for the sequencer. Synchronous clear, count enable, and a
// terminal-count flag that compares against a runtime limit. The counter
// saturates at the limit, so it never wraps past the last iteration.
//
// Ports
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset, forces count to 0
//   clr    : synchronous clear to 0 (wins over en)
//   en     : advance count by one unless already at limit
//   limit  : index of the last iteration
//   count  : current iteration index
//   tc     : count == limit
module step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc    = (count_q == limit);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
// Control sequencer for an iterative multiply/divide datapath. Accepts a
// request, strobes the operand load, iterates N steps, then pulses done.
// Every output decodes from registered state, so nothing combinational runs
// from an input to an output.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting; accepts start_mult / start_div
//   LOAD    | one cycle, operand load strobe, count = 0
//   RUN     | step every cycle, count 0..N-1; abort_exc ends early
//   DONE    | one cycle done pulse; may accept the next request directly
//
// Ports
//   clock, reset       : rising-edge clock, asynchronous active-low reset
//   start_mult         : multiply request (wins over start_div)
//   start_div          : divide request
//   abort_exc          : datapath exception, honoured in RUN only
//   load, step         : operand load strobe, datapath iterate enable
//   count              : current iteration index
//   op_div             : 1 while the latched operation is a divide
//   busy, done, exc    : in LOAD/RUN, completion pulse, last op aborted
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int MULT_STEPS = MULT_STEPS_DEF,
    parameter int DIV_STEPS  = DIV_STEPS_DEF,
    parameter int CNT_W      = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             abort_exc,
    output logic             load,
    output logic             step,
    output logic [CNT_W-1:0] count,
    output logic             op_div,
    output logic             busy,
    output logic             done,
    output logic             exc
);

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

    state_e state_q, state_d;
    logic   op_div_q, op_div_d;
    logic   exc_q, exc_d;
    logic   cnt_clr, cnt_en, cnt_tc;
    logic   accept;

    // Requests are only looked at when no operation is in flight.
    assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                    (start_mult || start_div);

    step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (op_div_q ? DIV_LAST : MULT_LAST),
        .count (count),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        exc_d    = exc_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d  = ST_LOAD;
                    op_div_d = !start_mult;
                    exc_d    = 1'b0;
                    cnt_clr  = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // On abort the count freezes at the aborted iteration.
                cnt_en = !abort_exc;
                if (abort_exc) begin
                    state_d = ST_DONE;
                    exc_d   = 1'b1;
                end else if (cnt_tc) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_div_q <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_div_q <= op_div_d;
            exc_q    <= exc_d;
        end
    end

    assign load   = (state_q == ST_LOAD);
    assign step   = (state_q == ST_RUN);
    assign busy   = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign op_div = op_div_q;
    assign exc    = exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer
// Timeline reference model: an accepted operation is described by the cycle
// its load strobe appears and how many step cycles it gets; every output of
// any cycle is derived from its offset against that timeline.
module tb_multdiv_sequencer;

    localparam int MS = 16;
    localparam int DS = 32;
    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start_mult = 1'b0;
    logic          start_div = 1'b0;
    logic          abort_exc = 1'b0;
    logic          load, step, busy, done, op_div, exc;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    multdiv_sequencer #(
        .MULT_STEPS (MS),
        .DIV_STEPS  (DS),
        .CNT_W      (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .abort_exc  (abort_exc),
        .load       (load),
        .step       (step),
        .count      (count),
        .op_div     (op_div),
        .busy       (busy),
        .done       (done),
        .exc        (exc)
    );

    // model: current cycle number, and the timeline of the latest operation
    int cyc = 0;
    bit have_op = 1'b0;
    int load_cyc = 0;
    int n_run = 0;     // step cycles this operation gets (shortened by abort)
    bit m_div = 1'b0;
    bit m_exc = 1'b0;

    bit e_load, e_step, e_busy, e_done;
    int e_count;

    function automatic void compute_exp();
        int rel;
        rel     = cyc - load_cyc;
        e_load  = have_op && (rel == 0);
        e_step  = have_op && (rel >= 1) && (rel <= n_run);
        e_done  = have_op && (rel == n_run + 1);
        e_busy  = e_load || e_step;
        if (!have_op)    e_count = 0;
        else if (e_load) e_count = 0;
        else if (e_step) e_count = rel - 1;
        else             e_count = n_run - 1;
    endfunction

    function automatic void model_reset();
        have_op = 1'b0;
        m_div   = 1'b0;
        m_exc   = 1'b0;
        compute_exp();
    endfunction

    // Advance across one rising edge using the inputs present at that edge.
    function automatic void model_edge();
        if (reset) begin
            if (e_step && abort_exc) begin
                n_run = cyc - load_cyc;
                m_exc = 1'b1;
            end else if (!e_busy && (start_mult || start_div)) begin
                have_op  = 1'b1;
                load_cyc = cyc + 1;
                m_div    = !start_mult;
                m_exc    = 1'b0;
                n_run    = m_div ? DS : MS;
            end
        end
        cyc++;
        compute_exp();
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        chk("load",   32'(load),   32'(e_load));
        chk("step",   32'(step),   32'(e_step));
        chk("busy",   32'(busy),   32'(e_busy));
        chk("done",   32'(done),   32'(e_done));
        chk("op_div", 32'(op_div), 32'(m_div));
        chk("exc",    32'(exc),    32'(m_exc));
        chk("count",  32'(count),  32'(e_count));
    endtask

    // One cycle: model crosses the edge, new inputs are driven, outputs are
    // checked at the falling edge. abort_at >= 0 raises abort_exc in the RUN
    // cycle whose count equals it.
    task automatic tick(input logic sm, input logic sd, input logic ab, input int abort_at);
        @(posedge clock);
        #1;
        model_edge();
        start_mult = sm;
        start_div  = sd;
        abort_exc  = ab || ((abort_at >= 0) && e_step && (e_count == abort_at));
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        // reset state, then a multiply requested in the first cycle after release
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        @(negedge clock);
        #2;
        reset      = 1'b1;
        start_mult = 1'b1;
        tick(1'b0, 1'b0, 1'b0, -1);
        idle(20);

        // divide
        tick(1'b0, 1'b1, 1'b0, -1);
        idle(36);

        // both requests together, then a divide request ignored mid-RUN
        tick(1'b1, 1'b1, 1'b0, -1);
        idle(8);
        tick(1'b0, 1'b1, 1'b0, -1);
        idle(15);

        // divide aborted at count 5, exc cleared by the next multiply
        tick(1'b0, 1'b1, 1'b0, -1);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b0, 5);
        idle(3);
        tick(1'b1, 1'b0, 1'b0, -1);
        idle(20);

        // multiply held continuously: back-to-back operations
        for (int i = 0; i < 60; i++) tick(1'b1, 1'b0, 1'b0, -1);
        idle(20);

        // asynchronous reset at count 7 of a divide
        begin
            int guard;
            guard = 0;
            tick(1'b0, 1'b1, 1'b0, -1);
            while (!(e_step && e_count == 7) && guard < 50) begin
                tick(1'b0, 1'b0, 1'b0, -1);
                guard++;
            end
            chk("reach_count7", 32'(e_step && e_count == 7), 32'd1);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        tick(1'b0, 1'b0, 1'b0, -1);
        tick(1'b1, 1'b0, 1'b0, -1);
        #2;
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, -1);
        idle(20);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            tick(($urandom % 10) == 0, ($urandom % 10) == 1, ($urandom % 25) == 0, -1);
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
